// File: rtl/grid_scan_ctrl.sv
// grid_scan_ctrl: scans a combinational position-to-grid converter one row at
// a time and builds a double-buffered ROWS x COLS frame for the LED driver.
//
// Each row is held for SETTLE+1 cycles so the wide compare logic can settle.
// On the last cycle of a row, grid_col is captured into the back buffer.
// After the last row, a single SWAP cycle flips the front/back select.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   frame_req    level request to start a frame scan (sampled in IDLE only)
//   busy         scan in progress; game state must stay stable
//   grid_row     row index driven to the converter, zero-extended to 16 bits
//   grid_col     converter output for grid_row
//   frame_done   one-cycle pulse when a new frame enters the front buffer
//   frame_cnt    completed-frame counter, wraps 255 -> 0
//   rd_row       display read row
//   rd_data      front[rd_row], one-cycle latency; 0 when rd_row >= ROWS
module grid_scan_ctrl #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_req,
  output logic                    busy,
  output logic [15:0]             grid_row,
  input  logic [COLS-1:0]         grid_col,
  output logic                    frame_done,
  output logic [7:0]              frame_cnt,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned GW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_nxt;
  logic [SW-1:0]   settle;
  logic [SW-1:0]   settle_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            cap_en;
  logic            swap_en;
  logic            front_sel;
  logic            rd_in_range;

  // Two frame buffers; front_sel picks the one the display reads.
  logic [COLS-1:0] frame_mem [2][ROWS];

  // Guards non-power-of-two ROWS where rd_row can exceed the frame.
  assign rd_in_range = (32'(rd_row) < ROWS);

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    settle_nxt = settle;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    cap_en     = 1'b0;
    swap_en    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req) begin
          state_nxt  = SCAN;
          row_nxt    = '0;
          settle_nxt = '0;
          busy_nxt   = 1'b1;
        end
      end
      SCAN: begin
        busy_nxt = 1'b1;
        if (settle == SW'(SETTLE)) begin
          // Row has settled: capture it and advance.
          cap_en     = 1'b1;
          settle_nxt = '0;
          if (row == RW'(ROWS - 1)) begin
            state_nxt = SWAP;
            row_nxt   = '0;
          end else begin
            row_nxt = row + RW'(1);
          end
        end else begin
          settle_nxt = settle + SW'(1);
        end
      end
      SWAP: begin
        swap_en   = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
        settle_nxt = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      settle     <= '0;
      busy       <= 1'b0;
      grid_row   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      front_sel  <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      settle     <= settle_nxt;
      busy       <= busy_nxt;
      grid_row   <= GW'(row_nxt);
      frame_done <= done_nxt;
      if (swap_en) begin
        front_sel <= ~front_sel;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Back-buffer capture and registered front-buffer read. On the swap edge
  // the read still sees the old front because front_sel updates at that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(ROWS); i++) begin
          frame_mem[b][i] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      if (cap_en) begin
        frame_mem[~front_sel][row] <= grid_col;
      end
      rd_data <= rd_in_range ? frame_mem[front_sel][rd_row] : '0;
    end
  end

endmodule

// File: tb/tb_grid_scan_ctrl.sv
// Self-checking bench for grid_scan_ctrl with a behavioural converter model:
// the food position {row, col} lights bit (15 - col) of its row.
module tb_grid_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_req;
  logic        busy;
  logic [15:0] grid_row;
  logic [15:0] grid_col;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic [7:0]  food;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Converter model: only the food cell is lit (snake length 0).
  assign grid_col = (grid_row == {12'd0, food[7:4]}) ? (16'h8000 >> food[3:0]) : 16'h0000;

  grid_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_req  (frame_req),
    .busy       (busy),
    .grid_row   (grid_row),
    .grid_col   (grid_col),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .rd_row     (rd_row),
    .rd_data    (rd_data)
  );

  typedef struct {
    logic [3:0]  row;
    logic [15:0] exp_a;  // after a frame with food 8'h35
    logic [15:0] exp_b;  // after a frame with food 8'h00
  } rd_vec_t;

  rd_vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Walk the read table; sel 0 = all zero, 1 = exp_a, 2 = exp_b.
  task automatic read_tbl(input int sel, input string name);
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      rd_row = tbl[i].row;
      tick();
      exp = (sel == 0) ? 16'h0000 : (sel == 1) ? tbl[i].exp_a : tbl[i].exp_b;
      check($sformatf("%s[%0d]", name, i), 32'(rd_data), 32'(exp));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_done;
    int done_cyc;
    int last;
    logic pulsed;
    logic expect_busy;

    for (int i = 0; i < 16; i++) begin
      tbl[i].row   = 4'(i);
      tbl[i].exp_a = 16'h0000;
      tbl[i].exp_b = 16'h0000;
    end
    tbl[3].exp_a = 16'h0400;
    tbl[0].exp_b = 16'h8000;

    // Reset held two cycles.
    reset = 1'b1; frame_req = 1'b0; rd_row = 4'd0; food = 8'h35;
    tick(); tick();
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_grid_row",   32'(grid_row),   32'd0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    reset = 1'b0;
    read_tbl(0, "rst_rd");

    // Single frame, food at 8'h35, one-cycle request pulse.
    food = 8'h35; frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    check("f1_busy_start", 32'(busy), 32'd1);
    check("f1_row_start",  32'(grid_row), 32'd0);
    for (int j = 1; j <= 48; j++) begin
      tick();
      check($sformatf("f1_grid_row_%0d", j), 32'(grid_row), (j < 48) ? 32'(j / 3) : 32'd0);
      if (j == 48) begin
        check("f1_busy_swap", 32'(busy), 32'd1);
        check("f1_no_done_swap", 32'(frame_done), 32'd0);
      end
    end
    tick();
    check("f1_done",      32'(frame_done), 32'd1);
    check("f1_busy_done", 32'(busy),       32'd0);
    check("f1_frame_cnt", 32'(frame_cnt),  32'd1);
    tick();
    check("f1_done_pulse", 32'(frame_done), 32'd0);
    read_tbl(1, "f1_rd");

    // Second frame with food 8'h00; extra request at grid_row 7 is ignored;
    // row 3 keeps reading the old front until the swap.
    food = 8'h00; rd_row = 4'd3; frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    pulsed = 1'b0; n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (frame_done) begin
        n_done++;
        done_cyc = c;
        check("f2_rd_swap_edge", 32'(rd_data), 32'h0400);
      end else if (n_done == 0) begin
        check($sformatf("f2_rd_scan_%0d", c), 32'(rd_data), 32'h0400);
      end else begin
        check($sformatf("f2_rd_new_%0d", c), 32'(rd_data), 32'h0000);
      end
      frame_req = 1'b0;
      if (!pulsed && grid_row == 16'd7) begin
        frame_req = 1'b1;
        pulsed = 1'b1;
      end
    end
    check("f2_pulse_seen", 32'(pulsed),   32'd1);
    check("f2_done_count", 32'(n_done),   32'd1);
    check("f2_latency",    32'(done_cyc), 32'd49);
    check("f2_frame_cnt",  32'(frame_cnt), 32'd2);
    read_tbl(2, "f2_rd");

    // Reset in the middle of a scan aborts it and clears both buffers.
    food = 8'h35; frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    for (int c = 0; c < 40 && grid_row != 16'd7; c++) tick();
    check("abort_reached_row7", 32'(grid_row), 32'd7);
    reset = 1'b1;
    tick();
    check("abort_busy",      32'(busy),       32'd0);
    check("abort_done",      32'(frame_done), 32'd0);
    check("abort_grid_row",  32'(grid_row),   32'd0);
    check("abort_frame_cnt", 32'(frame_cnt),  32'd0);
    check("abort_rd_data",   32'(rd_data),    32'd0);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (frame_done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    read_tbl(0, "abort_rd");

    // Request held high for ten back-to-back frames.
    frame_req = 1'b1; n_done = 0; last = 0; expect_busy = 1'b0;
    for (int c = 1; c <= 600 && n_done < 10; c++) begin
      tick();
      if (expect_busy) begin
        check("b2b_busy_restart", 32'(busy), 32'd1);
        expect_busy = 1'b0;
      end
      if (frame_done) begin
        n_done++;
        check("b2b_busy_gap", 32'(busy), 32'd0);
        if (n_done == 1) check("b2b_first_latency", 32'(c), 32'd50);
        else             check("b2b_period", 32'(c - last), 32'd50);
        last = c;
        if (n_done == 10) frame_req = 1'b0;
        else              expect_busy = 1'b1;
      end
    end
    check("b2b_done_count", 32'(n_done), 32'd10);
    tick();
    check("b2b_stays_idle", 32'(busy),      32'd0);
    check("b2b_frame_cnt",  32'(frame_cnt), 32'd10);

    // Run on to 256 completed frames: counter wraps to zero.
    frame_req = 1'b1; n_done = 0;
    for (int c = 0; c < 15000 && n_done < 246; c++) begin
      tick();
      if (frame_done) begin
        n_done++;
        if (n_done == 245) check("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        if (n_done == 246) frame_req = 1'b0;
      end
    end
    check("wrap_done_count", 32'(n_done),    32'd246);
    check("wrap_frame_cnt",  32'(frame_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
